// File: rtl/serial_comparator_word_serializer_pkg.sv
// Shared definitions for the word serializer and the downstream MSB-first serial comparator.
package serial_cmp_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_comparator_word_serializer_if.sv
// Operand handshake plus serial bit stream between the serializer and its neighbours.
interface serial_comparator_word_serializer_if #(
  parameter int WIDTH = serial_cmp_pkg::WIDTH_DEFAULT
);

  logic             up_valid;
  logic [WIDTH-1:0] up_a;
  logic [WIDTH-1:0] up_b;
  logic             up_ready;
  logic             cmp_clear;
  logic             a;
  logic             b;
  logic             bit_valid;
  logic             first_bit;
  logic             last_bit;

  // Serializer side: accepts operand pairs, drives the bit stream.
  modport master (
    input  up_valid, up_a, up_b,
    output up_ready, cmp_clear, a, b, bit_valid, first_bit, last_bit
  );

  // Environment side: offers operand pairs, consumes the bit stream.
  modport slave (
    output up_valid, up_a, up_b,
    input  up_ready, cmp_clear, a, b, bit_valid, first_bit, last_bit
  );

endinterface

// File: rtl/serial_comparator_word_serializer.sv
// Turns operand word pairs into MSB-first bit pairs for a serial comparator,
// accepting the next pair in the LSB cycle so words can stream without bubbles.
module serial_comparator_word_serializer
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  serial_comparator_word_serializer_if.master bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] sh_a_r;
  logic [WIDTH-1:0] sh_a_s;
  logic [WIDTH-1:0] sh_b_r;
  logic [WIDTH-1:0] sh_b_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_s;
  logic             first_r;
  logic             first_s;
  logic             shifting_s;
  logic             last_s;
  logic             ready_s;
  logic             xfer_s;

  assign shifting_s = (state_r == ST_SHIFT);
  assign last_s     = shifting_s && (cnt_r == '0);
  assign ready_s    = (state_r == ST_IDLE) || last_s;
  // Reset gating keeps the comparator from seeing a clear for a pair that is never taken.
  assign xfer_s     = bus.up_valid && ready_s && !rst;

  assign bus.up_ready  = ready_s;
  assign bus.cmp_clear = xfer_s;
  assign bus.bit_valid = shifting_s;
  assign bus.a         = shifting_s ? sh_a_r[WIDTH-1] : 1'b0;
  assign bus.b         = shifting_s ? sh_b_r[WIDTH-1] : 1'b0;
  assign bus.first_bit = shifting_s && first_r;
  assign bus.last_bit  = last_s;

  // Next-state, shift and counter decisions.
  always_comb begin
    state_s = state_r;
    sh_a_s  = sh_a_r;
    sh_b_s  = sh_b_r;
    cnt_s   = cnt_r;
    first_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          state_s = ST_SHIFT;
          sh_a_s  = bus.up_a;
          sh_b_s  = bus.up_b;
          cnt_s   = CW'(WIDTH - 1);
          first_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (xfer_s) begin
          // Reload on the LSB cycle: the next MSB follows with no gap.
          state_s = ST_SHIFT;
          sh_a_s  = bus.up_a;
          sh_b_s  = bus.up_b;
          cnt_s   = CW'(WIDTH - 1);
          first_s = 1'b1;
        end else if (last_s) begin
          state_s = ST_IDLE;
          sh_a_s  = {sh_a_r[WIDTH-2:0], 1'b0};
          sh_b_s  = {sh_b_r[WIDTH-2:0], 1'b0};
          cnt_s   = '0;
        end else begin
          state_s = ST_SHIFT;
          sh_a_s  = {sh_a_r[WIDTH-2:0], 1'b0};
          sh_b_s  = {sh_b_r[WIDTH-2:0], 1'b0};
          cnt_s   = cnt_r - CW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        sh_a_s  = '0;
        sh_b_s  = '0;
        cnt_s   = '0;
      end
    endcase
  end

  // State, shift registers, bit counter and first-bit flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sh_a_r  <= '0;
      sh_b_r  <= '0;
      cnt_r   <= '0;
      first_r <= 1'b0;
    end else begin
      state_r <= state_s;
      sh_a_r  <= sh_a_s;
      sh_b_r  <= sh_b_s;
      cnt_r   <= cnt_s;
      first_r <= first_s;
    end
  end

endmodule

// File: tb/tb_serial_comparator_word_serializer.sv
// Directed self-checking bench for the word serializer with a behavioural
// MSB-first serial comparator chained on its output.
module tb_serial_comparator_word_serializer;
  import serial_cmp_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  serial_comparator_word_serializer_if #(.WIDTH(8)) bus ();

  serial_comparator_word_serializer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream comparator: the first differing bit decides; cmp_clear restarts it.
  logic gt_r;
  logic lt_r;
  logic cmp_gt;
  logic cmp_lt;
  logic cmp_eq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gt_r <= 1'b0;
      lt_r <= 1'b0;
    end else if (bus.cmp_clear) begin
      gt_r <= 1'b0;
      lt_r <= 1'b0;
    end else if (bus.bit_valid && !gt_r && !lt_r) begin
      gt_r <= bus.a & ~bus.b;
      lt_r <= ~bus.a & bus.b;
    end
  end

  assign cmp_gt = gt_r | (!lt_r & bus.bit_valid & bus.a & ~bus.b);
  assign cmp_lt = lt_r | (!gt_r & bus.bit_valid & ~bus.a & bus.b);
  assign cmp_eq = !gt_r & !lt_r & (bus.a == bus.b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer a pair from idle and let it transfer; returns at the negedge of bit 1.
  task automatic start_word(input logic [7:0] wa, input logic [7:0] wb);
    bus.up_valid = 1'b1;
    bus.up_a     = wa;
    bus.up_b     = wb;
    #1;
    chk("start_ready", 32'(bus.up_ready), 32'd1);
    chk("start_clear", 32'(bus.cmp_clear), 32'd1);
    next_cycle();
  endtask

  // Check all 8 bit cycles of a word. Optionally offer the next pair in the
  // LSB cycle, or a disturbing pair at cycle index glitch_i.
  task automatic check_word(input string tag, input logic [7:0] wa, input logic [7:0] wb,
                            input logic chain, input logic [7:0] na, input logic [7:0] nb,
                            input int glitch_i);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && chain) begin
        bus.up_valid = 1'b1;
        bus.up_a     = na;
        bus.up_b     = nb;
      end else if (i == glitch_i) begin
        bus.up_valid = 1'b1;
        bus.up_a     = 8'hFF;
        bus.up_b     = 8'h00;
      end else begin
        bus.up_valid = 1'b0;
        bus.up_a     = 8'($urandom);
        bus.up_b     = 8'($urandom);
      end
      #1;
      chk({tag, "_valid"}, 32'(bus.bit_valid), 32'd1);
      chk({tag, "_a"}, 32'(bus.a), 32'(wa[7-i]));
      chk({tag, "_b"}, 32'(bus.b), 32'(wb[7-i]));
      chk({tag, "_first"}, 32'(bus.first_bit), (i == 0) ? 32'd1 : 32'd0);
      chk({tag, "_last"}, 32'(bus.last_bit), (i == 7) ? 32'd1 : 32'd0);
      chk({tag, "_ready"}, 32'(bus.up_ready), (i == 7) ? 32'd1 : 32'd0);
      chk({tag, "_clear"}, 32'(bus.cmp_clear), (i == 7 && chain) ? 32'd1 : 32'd0);
      if (i == 7) begin
        chk({tag, "_gt"}, 32'(cmp_gt), (wa > wb) ? 32'd1 : 32'd0);
        chk({tag, "_lt"}, 32'(cmp_lt), (wa < wb) ? 32'd1 : 32'd0);
        chk({tag, "_eq"}, 32'(cmp_eq), (wa == wb) ? 32'd1 : 32'd0);
      end
      next_cycle();
    end
  endtask

  task automatic check_idle(input string tag);
    bus.up_valid = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(bus.bit_valid), 32'd0);
    chk({tag, "_a"}, 32'(bus.a), 32'd0);
    chk({tag, "_b"}, 32'(bus.b), 32'd0);
    chk({tag, "_first"}, 32'(bus.first_bit), 32'd0);
    chk({tag, "_last"}, 32'(bus.last_bit), 32'd0);
    chk({tag, "_ready"}, 32'(bus.up_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    bus.up_valid = 1'b1;
    bus.up_a     = 8'h55;
    bus.up_b     = 8'hAA;

    // Reset state, with a pair offered to prove it is not cleared/taken.
    #2;
    check_idle("rst");
    bus.up_valid = 1'b1;
    #1;
    chk("rst_clear", 32'(bus.cmp_clear), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_valid", 32'(bus.bit_valid), 32'd0);
    rst          = 1'b0;
    bus.up_valid = 1'b0;
    next_cycle();
    check_idle("idle0");

    // A5/3C: a=1,0,1,0,0,1,0,1 b=0,0,1,1,1,1,0,0
    start_word(8'hA5, 8'h3C);
    check_word("w_a5", 8'hA5, 8'h3C, 1'b0, 8'h00, 8'h00, -1);
    check_idle("idle1");

    // Back-to-back 01/02 then 80/7F: 16 contiguous bit cycles.
    start_word(8'h01, 8'h02);
    check_word("b2b0", 8'h01, 8'h02, 1'b1, 8'h80, 8'h7F, -1);
    check_word("b2b1", 8'h80, 8'h7F, 1'b0, 8'h00, 8'h00, -1);
    check_idle("idle2");

    // Pair offered mid-word (cycle 4) must be refused and leave bits intact.
    start_word(8'hC3, 8'h96);
    check_word("midv", 8'hC3, 8'h96, 1'b0, 8'h00, 8'h00, 3);
    check_idle("idle3");

    // Asynchronous reset at bit 5 of F0/0F.
    ra = 8'hF0;
    rb = 8'h0F;
    start_word(ra, rb);
    for (int i = 0; i < 4; i++) begin
      bus.up_valid = 1'b0;
      #1;
      chk("rstw_a", 32'(bus.a), 32'(ra[7-i]));
      chk("rstw_b", 32'(bus.b), 32'(rb[7-i]));
      next_cycle();
    end
    #1;
    chk("rstw_bit5_valid", 32'(bus.bit_valid), 32'd1);
    chk("rstw_bit5_a", 32'(bus.a), 32'd0);
    chk("rstw_bit5_b", 32'(bus.b), 32'd1);
    #1;
    rst          = 1'b1;
    bus.up_valid = 1'b1;
    #1;
    check_idle("rst_async");
    bus.up_valid = 1'b1;
    #1;
    chk("rst_async_clear", 32'(bus.cmp_clear), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First edge after release takes a fresh word: equal operands 5A/5A.
    start_word(8'h5A, 8'h5A);
    check_word("eq", 8'h5A, 8'h5A, 1'b0, 8'h00, 8'h00, -1);
    check_idle("idle4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_comparator_word_serializer.md
SERIAL_COMPARATOR_WORD_SERIALIZER -- requirements
Module: serial_comparator_word_serializer

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each operand word; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 up_valid  input  1  operand pair present on up_a/up_b.
REQ-005 up_a  input  WIDTH  operand A, unsigned.
REQ-006 up_b  input  WIDTH  operand B, unsigned.
REQ-007 up_ready  output  1  block accepts the pair this cycle.
REQ-008 cmp_clear  output  1  one-cycle pulse; the downstream MSB-first serial comparator takes it as its synchronous clear.
REQ-009 a  output  1  current serial bit of operand A.
REQ-010 b  output  1  current serial bit of operand B.
REQ-011 bit_valid  output  1  a/b carry a valid bit this cycle.
REQ-012 first_bit  output  1  current bit is the MSB of the word.
REQ-013 last_bit  output  1  current bit is the LSB of the word.

Function
REQ-014 Transfer on up_valid & up_ready at a rising edge; up_a/up_b captured in internal shift registers.
REQ-015 FSM states: ST_IDLE (no word), ST_SHIFT (emitting bits).
REQ-016 ST_IDLE: up_ready=1, bit_valid=0, a=b=0; on transfer -> ST_SHIFT, bit counter = WIDTH-1.
REQ-017 ST_SHIFT: bit_valid=1; a/b = MSB of the shift registers; registers shift left by one and counter decrements each cycle.
REQ-018 Latency: a transfer at edge T presents the MSB in the cycle after T; bits occupy WIDTH consecutive cycles, MSB first, no gaps.
REQ-019 first_bit=1 only in the first ST_SHIFT cycle of a word; last_bit=1 only when counter == 0.
REQ-020 up_ready=1 in ST_IDLE and in the last_bit cycle; 0 in all other ST_SHIFT cycles.
REQ-021 Transfer in the last_bit cycle: reload registers and counter; stay in ST_SHIFT; next word's MSB follows immediately (back-to-back, zero bubble).
REQ-022 No transfer in the last_bit cycle -> ST_IDLE.
REQ-023 cmp_clear = up_valid & up_ready, combinational, so the comparator state is clear when the new MSB arrives; the previous word's result remains valid during its last_bit cycle.
REQ-024 up_a/up_b ignored when no transfer occurs; values outside a transfer never reach a/b.
REQ-025 When up_valid is held with up_ready=0, the pending pair is not consumed and does not change the outputs.

Reset
REQ-026 rst asserted at any time, including mid-word, forces ST_IDLE immediately without a clock edge.
REQ-027 Reset values: up_ready=1, bit_valid=0, a=0, b=0, first_bit=0, last_bit=0, shift registers and counter 0.
REQ-028 cmp_clear is 0 while rst is asserted; a word in flight at reset is discarded, not resumed.
REQ-029 First transfer permitted at the first rising edge after rst deasserts.

Structure
REQ-030 Shared package serial_cmp_pkg holds the state enum type and the default WIDTH constant; the downstream comparator and this block import it.
REQ-031 Single module with no sub-modules; the FSM, counter and two shift registers are local, and the counter width is $clog2(WIDTH).

Verification
REQ-032 WIDTH=8, transfer up_a=8'hA5, up_b=8'h3C -> next 8 cycles a=1,0,1,0,0,1,0,1 and b=0,0,1,1,1,1,0,0; first_bit on cycle 1, last_bit on cycle 8.
REQ-033 Back-to-back: pair 8'h01/8'h02, then 8'h80/8'h7F with up_valid held -> 16 contiguous bit_valid cycles; cmp_clear pulses at both transfers; comparator chained downstream reports less, then greater, in the respective last_bit cycles.
REQ-034 up_valid pulsed mid-word (cycle 4) with 8'hFF/8'h00 -> up_ready=0, no cmp_clear, current word bits unaltered.
REQ-035 rst asserted asynchronously at bit 5 of 8'hF0/8'h0F -> bit_valid drops to 0 before the next edge; after release the next transfer starts a fresh MSB with first_bit=1.
REQ-036 Equal operands 8'h5A/8'h5A, with the comparator chained downstream -> a==b on every bit and a_eq_b=1 in the last_bit cycle.
